// File: rtl/divisor_ctrl.sv
// divisor_ctrl: run-time programmable clock divider controller.
//   Sequences a period counter (start/stop/retune/one-shot bursts) and
//   produces a one-cycle tick enable plus a 50%-duty square wave clk_out.
//   Retunes received while running are held in a shadow register and only
//   applied on a period boundary, so no short periods are ever produced.
// Optional feature macro: DIVCTRL_ONESHOT_EN enables burst (one-shot) mode;
//   when undefined cfg_mode/cfg_count are ignored and done is tied low.
// Ports:
//   clk_in, rst         clock, asynchronous active-high reset
//   cfg_valid/cfg_ready configuration handshake
//   cfg_div             cycles per tick (0 treated as 1)
//   cfg_mode, cfg_count 0=continuous/1=burst, ticks per burst (0 = 256)
//   start, stop         run control levels
//   tick, clk_out       period enable pulse and square wave
//   busy, done          running flag, end-of-burst pulse
module divisor_ctrl #(
  parameter int unsigned WIDTH       = 27,
  parameter int unsigned DEFAULT_DIV = 50000000
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_div,
  input  logic             cfg_mode,
  input  logic [7:0]       cfg_count,
  input  logic             start,
  input  logic             stop,
  output logic             tick,
  output logic             clk_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] sh_div_q;
  logic             sh_vld_q;
  logic             tick_q;
  logic             clk_out_q;
  logic             busy_q;
  logic             cfg_ready_q;

  logic             accept;
  logic             wrap;
  logic             last_tick;
  logic [WIDTH-1:0] div_in;

`ifdef DIVCTRL_ONESHOT_EN
  logic       mode_q;
  logic [7:0] count_q;
  logic       sh_mode_q;
  logic [7:0] sh_count_q;
  logic [8:0] burst_q;
  logic       done_q;

  // A burst count of 0 stands for 256 ticks.
  function automatic logic [8:0] burst_len(input logic [7:0] c);
    return (c == 8'd0) ? 9'd256 : {1'b0, c};
  endfunction
`else
  logic unused_cfg;
  assign unused_cfg = ^{cfg_mode, cfg_count};
`endif

  always_comb begin
    accept = cfg_valid && cfg_ready_q;
    div_in = (cfg_div == '0) ? WIDTH'(1) : cfg_div;
    wrap   = (cnt_q == (div_q - WIDTH'(1)));
`ifdef DIVCTRL_ONESHOT_EN
    last_tick = mode_q && (burst_q == 9'd1);
`else
    last_tick = 1'b0;
`endif
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      div_q       <= WIDTH'(DEFAULT_DIV);
      sh_div_q    <= '0;
      sh_vld_q    <= 1'b0;
      tick_q      <= 1'b0;
      clk_out_q   <= 1'b0;
      busy_q      <= 1'b0;
      cfg_ready_q <= 1'b0;
`ifdef DIVCTRL_ONESHOT_EN
      mode_q     <= 1'b0;
      count_q    <= 8'd1;
      sh_mode_q  <= 1'b0;
      sh_count_q <= 8'd1;
      burst_q    <= '0;
      done_q     <= 1'b0;
`endif
    end else begin
      tick_q <= 1'b0;
`ifdef DIVCTRL_ONESHOT_EN
      done_q <= 1'b0;
`endif
      unique case (state_q)
        S_IDLE: begin
          cnt_q       <= '0;
          clk_out_q   <= 1'b0;
          busy_q      <= 1'b0;
          cfg_ready_q <= 1'b1;
          sh_vld_q    <= 1'b0;
          if (accept) begin
            div_q <= div_in;
`ifdef DIVCTRL_ONESHOT_EN
            mode_q  <= cfg_mode;
            count_q <= cfg_count;
`endif
          end
          if (start && !stop) begin
            state_q <= S_RUN;
            busy_q  <= 1'b1;
`ifdef DIVCTRL_ONESHOT_EN
            // A config accepted on the start edge governs this run.
            burst_q <= burst_len(accept ? cfg_count : count_q);
`endif
          end
        end

        S_RUN: begin
          if (stop) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            sh_vld_q    <= 1'b0;
            clk_out_q   <= 1'b0;
            busy_q      <= 1'b0;
            cfg_ready_q <= 1'b1;
          end else if (wrap) begin
            cnt_q     <= '0;
            tick_q    <= 1'b1;
            clk_out_q <= ~clk_out_q;
            // Period boundary: pending retune becomes active.
            if (sh_vld_q) begin
              div_q    <= sh_div_q;
              sh_vld_q <= 1'b0;
`ifdef DIVCTRL_ONESHOT_EN
              mode_q  <= sh_mode_q;
              count_q <= sh_count_q;
`endif
            end
            if (last_tick) begin
              state_q     <= S_IDLE;
              busy_q      <= 1'b0;
              clk_out_q   <= 1'b0;
              cfg_ready_q <= 1'b1;
`ifdef DIVCTRL_ONESHOT_EN
              done_q <= 1'b1;
`endif
              // Back in IDLE, so a coincident config loads directly.
              if (accept) begin
                div_q <= div_in;
`ifdef DIVCTRL_ONESHOT_EN
                mode_q  <= cfg_mode;
                count_q <= cfg_count;
`endif
              end
            end else begin
`ifdef DIVCTRL_ONESHOT_EN
              if (sh_vld_q && ((sh_mode_q != mode_q) || (sh_count_q != count_q)))
                burst_q <= burst_len(sh_count_q);
              else if (mode_q)
                burst_q <= burst_q - 9'd1;
`endif
              if (accept) begin
                sh_div_q    <= div_in;
                sh_vld_q    <= 1'b1;
                cfg_ready_q <= 1'b0;
`ifdef DIVCTRL_ONESHOT_EN
                sh_mode_q  <= cfg_mode;
                sh_count_q <= cfg_count;
`endif
              end else begin
                cfg_ready_q <= 1'b1;
              end
            end
          end else begin
            cnt_q <= cnt_q + WIDTH'(1);
            if (accept) begin
              sh_div_q    <= div_in;
              sh_vld_q    <= 1'b1;
              cfg_ready_q <= 1'b0;
`ifdef DIVCTRL_ONESHOT_EN
              sh_mode_q  <= cfg_mode;
              sh_count_q <= cfg_count;
`endif
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tick      = tick_q;
  assign clk_out   = clk_out_q;
  assign busy      = busy_q;
  assign cfg_ready = cfg_ready_q;
`ifdef DIVCTRL_ONESHOT_EN
  assign done = done_q;
`else
  assign done = 1'b0;
`endif

endmodule

// File: tb/tb_divisor_ctrl.sv
// Testbench for divisor_ctrl: table of divisor/period vectors, directed
// multi-cycle sequences (reset, retune, stop-on-tick, async reset, burst),
// and random stimulus compared against a period-level reference model.
module tb_divisor_ctrl;

  localparam int unsigned W = 27;

  logic         clk_in;
  logic         rst;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [W-1:0] cfg_div;
  logic         cfg_mode;
  logic [7:0]   cfg_count;
  logic         start;
  logic         stop;
  logic         tick;
  logic         clk_out;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  divisor_ctrl #(.WIDTH(W), .DEFAULT_DIV(4)) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_div   (cfg_div),
    .cfg_mode  (cfg_mode),
    .cfg_count (cfg_count),
    .start     (start),
    .stop      (stop),
    .tick      (tick),
    .clk_out   (clk_out),
    .busy      (busy),
    .done      (done)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  // Reference model: tracks run state, cycles elapsed in the current period,
  // active divisor and a pending retune.
  bit m_run, m_sh, m_clk, m_tick, m_ready;
  int m_div, m_shdiv, m_phase;

  task automatic model_step(input bit v, input int d, input bit st, input bit sp);
    int  eff;
    bit  acc;
    eff    = (d == 0) ? 1 : d;
    acc    = v && m_ready;
    m_tick = 1'b0;
    if (!m_run) begin
      if (acc) m_div = eff;
      if (st && !sp) begin
        m_run   = 1'b1;
        m_phase = 0;
      end
      m_clk   = 1'b0;
      m_sh    = 1'b0;
      m_ready = 1'b1;
    end else if (sp) begin
      m_run   = 1'b0;
      m_sh    = 1'b0;
      m_clk   = 1'b0;
      m_ready = 1'b1;
    end else begin
      m_phase++;
      if (m_phase == m_div) begin
        m_phase = 0;
        m_tick  = 1'b1;
        m_clk   = !m_clk;
        if (m_sh) begin
          m_div = m_shdiv;
          m_sh  = 1'b0;
        end
      end
      if (acc) begin
        m_sh    = 1'b1;
        m_shdiv = eff;
      end
      m_ready = !m_sh;
    end
  endtask

  typedef struct {
    logic [W-1:0] div;
    int           period;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int  ntick, ndone, nalone;
    bit  v, st, sp;
    int  d;

    tbl[0] = '{div: 27'd0, period: 1};
    tbl[1] = '{div: 27'd1, period: 1};
    tbl[2] = '{div: 27'd2, period: 2};
    tbl[3] = '{div: 27'd3, period: 3};
    tbl[4] = '{div: 27'd7, period: 7};
    tbl[5] = '{div: 27'd5, period: 5};

    rst = 1'b0; cfg_valid = 1'b0; cfg_div = '0; cfg_mode = 1'b0;
    cfg_count = 8'd0; start = 1'b0; stop = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_tick", tick, 0);
    chk("rst_clk_out", clk_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", cfg_ready, 0);
    cyc(); cyc();
    chk("rst_ready_held", cfg_ready, 0);
    #2 rst = 1'b0;
    cyc();
    chk("ready_after_release", cfg_ready, 1);
    chk("busy_idle", busy, 0);

    // Default divisor of 4.
    start = 1'b1; cyc(); start = 1'b0;
    chk("busy_after_start", busy, 1);
    for (int k = 1; k <= 12; k++) begin
      cyc();
      chk($sformatf("def_tick_%0d", k), tick, (k % 4 == 0) ? 1 : 0);
      chk($sformatf("def_clk_%0d", k), clk_out, (k / 4) % 2);
    end
    chk("def_busy", busy, 1);
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("stop_busy", busy, 0);
    chk("stop_clk", clk_out, 0);

    // Table: config accepted on the start edge governs the run.
    for (int i = 0; i < 6; i++) begin
      cfg_valid = 1'b1; cfg_div = tbl[i].div; cfg_mode = 1'b0; start = 1'b1;
      cyc();
      cfg_valid = 1'b0; start = 1'b0;
      chk($sformatf("tbl%0d_busy", i), busy, 1);
      for (int k = 1; k <= 2 * tbl[i].period; k++) begin
        cyc();
        chk($sformatf("tbl%0d_tick_%0d", i, k), tick, (k % tbl[i].period == 0) ? 1 : 0);
      end
      stop = 1'b1; cyc(); stop = 1'b0;
    end

    // Retune 5 -> 3 accepted mid-period.
    cfg_valid = 1'b1; cfg_div = 27'd5; start = 1'b1; cyc();
    cfg_valid = 1'b0; start = 1'b0;
    cyc(); cyc();
    cfg_valid = 1'b1; cfg_div = 27'd3; cyc();
    cfg_valid = 1'b0;
    chk("rt_ready_acc", cfg_ready, 0);
    cyc();
    chk("rt_ready_mid", cfg_ready, 0);
    chk("rt_tick4", tick, 0);
    cyc();
    chk("rt_tick5", tick, 1);
    chk("rt_ready_wrap", cfg_ready, 1);
    for (int k = 6; k <= 11; k++) begin
      cyc();
      chk($sformatf("rt_tick_%0d", k), tick, ((k - 5) % 3 == 0) ? 1 : 0);
    end
    stop = 1'b1; cyc(); stop = 1'b0;

    // Stop on the tick edge discards a pending retune.
    cfg_valid = 1'b1; cfg_div = 27'd4; start = 1'b1; cyc();
    start = 1'b0; cfg_div = 27'd2; cyc();
    cfg_valid = 1'b0;
    chk("st_ready_pending", cfg_ready, 0);
    cyc(); cyc();
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("st_tick", tick, 0);
    chk("st_done", done, 0);
    chk("st_busy", busy, 0);
    chk("st_clk", clk_out, 0);
    chk("st_ready", cfg_ready, 1);
    start = 1'b1; cyc(); start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      chk($sformatf("st_restart_tick_%0d", k), tick, (k == 4) ? 1 : 0);
    end
    stop = 1'b1; cyc(); stop = 1'b0;

    // Asynchronous reset mid-run, not aligned to an edge.
    cfg_valid = 1'b1; cfg_div = 27'd3; start = 1'b1; cyc();
    cfg_valid = 1'b0; start = 1'b0;
    cyc(); cyc(); cyc();
    chk("ar_pre_tick", tick, 1);
    chk("ar_pre_clk", clk_out, 1);
    #2 rst = 1'b1;
    #1;
    chk("ar_tick", tick, 0);
    chk("ar_clk", clk_out, 0);
    chk("ar_busy", busy, 0);
    chk("ar_done", done, 0);
    chk("ar_ready", cfg_ready, 0);
    #4 rst = 1'b0;
    cyc();
    chk("ar_ready_after", cfg_ready, 1);
    start = 1'b1; cyc(); start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      chk($sformatf("ar_default_tick_%0d", k), tick, (k == 4) ? 1 : 0);
    end
    stop = 1'b1; cyc(); stop = 1'b0;

`ifdef DIVCTRL_ONESHOT_EN
    // Burst of 3 with div 2.
    cfg_valid = 1'b1; cfg_div = 27'd2; cfg_mode = 1'b1; cfg_count = 8'd3; start = 1'b1;
    cyc();
    cfg_valid = 1'b0; start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      chk($sformatf("os_tick_%0d", k), tick, (k % 2 == 0 && k <= 6) ? 1 : 0);
      chk($sformatf("os_done_%0d", k), done, (k == 6) ? 1 : 0);
      chk($sformatf("os_busy_%0d", k), busy, (k < 6) ? 1 : 0);
      chk($sformatf("os_clk_%0d", k), clk_out, (k >= 2 && k < 4) ? 1 : 0);
    end
    // Burst count 0 means 256 ticks.
    cfg_valid = 1'b1; cfg_count = 8'd0; start = 1'b1;
    cyc();
    cfg_valid = 1'b0; start = 1'b0;
    ntick = 0; ndone = 0; nalone = 0;
    for (int k = 1; k <= 600; k++) begin
      cyc();
      if (tick) ntick++;
      if (done) ndone++;
      if (done && !tick) nalone++;
    end
    chk("os256_ticks", ntick, 256);
    chk("os256_done", ndone, 1);
    chk("os256_done_alone", nalone, 0);
    chk("os256_busy", busy, 0);
`else
    // Without burst support the mode is ignored and runs continue.
    cfg_valid = 1'b1; cfg_div = 27'd2; cfg_mode = 1'b1; cfg_count = 8'd3; start = 1'b1;
    cyc();
    cfg_valid = 1'b0; start = 1'b0;
    ntick = 0; ndone = 0;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      if (tick) ntick++;
      if (done) ndone++;
    end
    chk("cont_ticks", ntick, 5);
    chk("cont_done", ndone, 0);
    chk("cont_busy", busy, 1);
    stop = 1'b1; cyc(); stop = 1'b0;
`endif

    // Random stimulus against the reference model (continuous mode).
    cfg_valid = 1'b1; cfg_div = 27'd3; cfg_mode = 1'b0; cfg_count = 8'd1; cyc();
    cfg_valid = 1'b0;
    m_run = 1'b0; m_sh = 1'b0; m_clk = 1'b0; m_tick = 1'b0; m_ready = 1'b1;
    m_div = 3; m_shdiv = 0; m_phase = 0;
    for (int i = 0; i < 3000; i++) begin
      v  = ($urandom_range(0, 9) < 3);
      d  = int'($urandom_range(0, 6));
      st = ($urandom_range(0, 9) == 0);
      sp = ($urandom_range(0, 39) == 0);
      cfg_valid = v; cfg_div = W'(d); start = st; stop = sp;
      cfg_count = 8'($urandom);
      cyc();
      model_step(v, d, st, sp);
      chk($sformatf("rnd%0d_tick", i), tick, m_tick);
      chk($sformatf("rnd%0d_clk", i), clk_out, m_clk);
      chk($sformatf("rnd%0d_busy", i), busy, m_run);
      chk($sformatf("rnd%0d_ready", i), cfg_ready, m_ready);
      chk($sformatf("rnd%0d_done", i), done, 0);
    end
    cfg_valid = 1'b0; start = 1'b0; stop = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
